c1_pool_scheduler: RTL

Sequencer that turns the raster-order conv1 output stream (6 channels, one pixel per beat) into packed 2x2 pooling windows for the c1 max-pooling stage. It buffers one even row of pixels and emits one window per channel on every odd-row/odd-column beat. It counts the pooled results that come back and signals end of frame. It sits between the conv1 array and the c1 max-pooling unit and is the only driver of that unit's `pool_valid` and `pool_ch*` inputs.

---
 rtl/c1_pool_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/c1_pool_scheduler.sv
// Turns the raster conv1 stream into packed 2x2 pooling windows and counts the pooled results.
// Optional C1_POOL_ERR_EN adds a sticky err output. States: IDLE idle | RUN take beats | DRAIN await results | DONE end pulse
module c1_pool_scheduler #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        conv_valid,
   input  logic [7:0]  conv_ch0,
   input  logic [7:0]  conv_ch1,
   input  logic [7:0]  conv_ch2,
   input  logic [7:0]  conv_ch3,
   input  logic [7:0]  conv_ch4,
   input  logic [7:0]  conv_ch5,
   output logic        pool_valid,
   output logic [31:0] pool_ch0,
   output logic [31:0] pool_ch1,
   output logic [31:0] pool_ch2,
   output logic [31:0] pool_ch3,
   output logic [31:0] pool_ch4,
   output logic [31:0] pool_ch5,
   input  logic        mp_out_valid,
   output logic        busy,
   output logic        frame_done,
   output logic [11:0] pool_cnt
`ifdef C1_POOL_ERR_EN
   ,output logic       err
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int N  = (IMG_W / 2) * (IMG_H / 2);
   localparam logic [11:0]   N_CNT    = 12'(N);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [47:0]   line_buf_q [IMG_W];
   logic [47:0]   line_buf_d [IMG_W];
   logic [47:0]   prev_pix_q, prev_pix_d;
   logic          pool_valid_q, pool_valid_d;
   logic [31:0]   pool_data_q [6];
   logic [31:0]   pool_data_d [6];
   logic [11:0]   pool_cnt_q, pool_cnt_d;
   logic [47:0]   cur_pix;
   logic          counting;

   assign cur_pix  = {conv_ch0, conv_ch1, conv_ch2, conv_ch3, conv_ch4, conv_ch5};
   assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      line_buf_d   = line_buf_q;
      prev_pix_d   = prev_pix_q;
      pool_valid_d = 1'b0;
      pool_data_d  = pool_data_q;
      pool_cnt_d   = pool_cnt_q;

      // Saturate at N; an extra result is a protocol error, not a count.
      if (counting && mp_out_valid && (pool_cnt_q != N_CNT))
         pool_cnt_d = pool_cnt_q + 12'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               col_d      = '0;
               row_d      = '0;
               pool_cnt_d = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (conv_valid) begin
               if (!row_q[0]) begin
                  line_buf_d[col_q] = cur_pix;
               end else if (!col_q[0]) begin
                  prev_pix_d = cur_pix;
               end else begin
                  pool_valid_d = 1'b1;
                  for (int c = 0; c < 6; c++) begin
                     pool_data_d[c] = {line_buf_q[col_q - 1'b1][47-8*c -: 8],
                                       line_buf_q[col_q][47-8*c -: 8],
                                       prev_pix_q[47-8*c -: 8],
                                       cur_pix[47-8*c -: 8]};
                  end
               end
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) state_d = S_DRAIN;
                  else                   row_d   = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // Look at the next count so frame_done follows the last result by one cycle.
            if (pool_cnt_d == N_CNT) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         prev_pix_q   <= '0;
         pool_valid_q <= 1'b0;
         pool_cnt_q   <= '0;
         for (int i = 0; i < IMG_W; i++) line_buf_q[i] <= '0;
         for (int c = 0; c < 6; c++)     pool_data_q[c] <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         prev_pix_q   <= prev_pix_d;
         pool_valid_q <= pool_valid_d;
         pool_cnt_q   <= pool_cnt_d;
         line_buf_q   <= line_buf_d;
         pool_data_q  <= pool_data_d;
      end
   end

   assign pool_valid = pool_valid_q;
   assign pool_ch0   = pool_data_q[0];
   assign pool_ch1   = pool_data_q[1];
   assign pool_ch2   = pool_data_q[2];
   assign pool_ch3   = pool_data_q[3];
   assign pool_ch4   = pool_data_q[4];
   assign pool_ch5   = pool_data_q[5];
   assign pool_cnt   = pool_cnt_q;
   assign busy       = counting;
   assign frame_done = (state_q == S_DONE);

`ifdef C1_POOL_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (conv_valid && (state_q != S_RUN)) err_d = 1'b1;
      if (mp_out_valid && !counting) err_d = 1'b1;
      if (mp_out_valid && counting && (pool_cnt_q == N_CNT)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule
